// File: rtl/command_encoder_if.sv
// Request handshake and SPI link signals of the command encoder.
interface command_encoder_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_type;
  logic [2:0] req_color;
  logic [4:0] req_row;
  logic [4:0] req_col;
  logic [9:0] req_score;
  logic       sck;
  logic       mosi;
  logic       cs_n;
  logic       busy;
  logic       done;

  // Requester side: issues requests, observes the link.
  modport master (
    output req_valid, req_type, req_color, req_row, req_col, req_score,
    input  req_ready, sck, mosi, cs_n, busy, done
  );

  // Encoder side: accepts requests, drives the link.
  modport slave (
    input  req_valid, req_type, req_color, req_row, req_col, req_score,
    output req_ready, sck, mosi, cs_n, busy, done
  );
endinterface

// File: rtl/command_encoder.sv
// SPI mode-0 master that packs colour-write / score-update requests into
// 3-byte packets {command, databyte1, databyte2} and shifts them out MSB first.
module command_encoder #(
  parameter int unsigned CLK_DIV        = 4,
  parameter logic [7:0]  COLOR_CMD_BASE = 8'h80,
  parameter logic [7:0]  SCORE_CMD      = 8'h40
) (
  input  logic             clk,
  input  logic             reset,
  command_encoder_if.slave bus
);

  localparam int unsigned   CntW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShiftHi, StShiftLo, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [23:0]     sr_q, sr_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            req_ready_q, req_ready_d;

  logic [23:0]     packet;
  logic            accept;
  logic            cnt_last;
  logic            shifting;

  // Build the packet from the request fields; unused fields are ignored.
  always_comb begin
    if (bus.req_type) begin
      packet = {SCORE_CMD, 6'b0, bus.req_score[9:8], bus.req_score[7:0]};
    end else begin
      packet = {COLOR_CMD_BASE[7:3], bus.req_color, 3'b0, bus.req_row, 3'b0, bus.req_col};
    end
  end

  // Next-state logic: phase sequencing, half-period counting and shifting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    accept   = bus.req_valid && req_ready_q;
    cnt_last = (cnt_q == CntLast);
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
          cnt_d   = '0;
          bit_d   = 5'd23;
          sr_d    = packet;
        end
      end
      StSetup: begin
        if (cnt_last) begin
          state_d = StShiftHi;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShiftHi: begin
        if (cnt_last) begin
          state_d = StShiftLo;
          cnt_d   = '0;
          // mosi advances on the falling edge, except after the final bit.
          if (bit_q != 5'd0) begin
            sr_d = {sr_q[22:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShiftLo: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == 5'd0) begin
            state_d = StGap;
          end else begin
            state_d = StShiftHi;
            bit_d   = bit_q - 5'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_last) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the link pins are glitch-free.
  always_comb begin
    shifting    = (state_d == StSetup) || (state_d == StShiftHi) || (state_d == StShiftLo);
    sck_d       = (state_d == StShiftHi);
    cs_n_d      = !shifting;
    mosi_d      = shifting && sr_d[23];
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StGap) && (cnt_d == CntLast);
    req_ready_d = (state_d == StIdle);
  end

  // State and output registers; reset drops any packet in flight immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.sck       = sck_q;
  assign bus.mosi      = mosi_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/command_encoder.md
Name: command_encoder

Overview:
- SPI-master command transmitter; the far end of the FPGA command decoder link.
- Accepts one high-level request per handshake: a framebuffer colour write or a score update.
- Packs each request into the 3-byte packet {command, databyte1, databyte2} and shifts it out in SPI mode 0, MSB first.
- Used as the bench/link driver for the decoder path and as the on-chip loopback source for bring-up.

Parameters:
- CLK_DIV, 4, SCK half-period in clk cycles; legal range >= 1.
- COLOR_CMD_BASE, 8'h80, colour opcode; bits [2:0] are replaced by the colour. Must match the decoder's colour pattern in command_header.sv.
- SCORE_CMD, 8'h40, score-update opcode. Must match the decoder's score pattern in command_header.sv.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_type  input  1  0 = colour write, 1 = score update.
- req_color  input  3  colour index (colour write only).
- req_row  input  5  tile row (colour write only).
- req_col  input  5  tile column (colour write only).
- req_score  input  10  score value (score update only).
- sck  output  1  SPI clock; idles low.
- mosi  output  1  SPI data.
- cs_n  output  1  SPI chip select, active low.
- busy  output  1  high while a transaction is in progress.
- done  output  1  one-cycle pulse when a transaction completes.

Behaviour:
- Reset (reset low), asynchronous and immediate:
  - sck=0, mosi=0, cs_n=1, busy=0, done=0, req_ready=0.
  - FSM goes to IDLE; any packet in flight is dropped with no partial completion.
  - req_ready=1 from the first clk edge after reset deasserts.
- Packet formation, latched into a 24-bit shift register on accept (req_valid && req_ready at a clk edge):
  - Colour write: byte0 = {COLOR_CMD_BASE[7:3], req_color}; byte1 = {3'b0, req_row}; byte2 = {3'b0, req_col}.
  - Score update: byte0 = SCORE_CMD; byte1 = {6'b0, req_score[9:8]}; byte2 = req_score[7:0].
  - Inputs are don't-care after the accept edge. Fields not used by the selected req_type are ignored.
- FSM: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> GAP -> IDLE. A half-period counter counts 0..CLK_DIV-1.
  - IDLE: req_ready=1, busy=0, cs_n=1, sck=0. On accept go to SETUP.
  - SETUP (CLK_DIV cycles): cs_n=0, sck=0, mosi=bit23, busy=1, req_ready=0.
  - SHIFT_HI (CLK_DIV cycles): sck=1; mosi held stable. The receiver samples on the rising edge.
  - SHIFT_LO (CLK_DIV cycles): sck=0. On entry, mosi advances to the next bit. After the low phase of bit 0, mosi holds bit 0 and the FSM goes to GAP.
  - GAP (CLK_DIV cycles): cs_n=1, sck=0, mosi=0. done=1 on the last GAP cycle. IDLE follows on the next cycle.
- Timing from accept edge t0:
  - cs_n low over t0+1 .. t0+49*CLK_DIV.
  - Exactly 24 sck rising edges.
  - done at t0+50*CLK_DIV.
  - req_ready=1 at t0+50*CLK_DIV+1.
- Handshake:
  - Exactly one packet per accept.
  - req_valid while busy is ignored.
  - A req_valid held high continuously yields back-to-back packets separated by the GAP plus one IDLE cycle; this is the minimum cs_n-high time of CLK_DIV+1 cycles.
- Mid-transfer reset: cs_n rises asynchronously and sck/mosi go low. No done pulse is produced.
- CLK_DIV=1: every phase lasts one cycle; the timing formulas above still hold.

Test Plan:
- CLK_DIV=4; colour write color=5, row=7, col=12 -> mosi bits at sck rises = 0x85, 0x07, 0x0C; cs_n low 196 cycles; done at t0+200; req_ready at t0+201.
- Score update req_score=10'h2A5 -> bytes 0x40, 0x02, 0xA5. A bench decoder model reports score=677 and no write enable.
- req_valid held high with two queued requests (colour 3 at row 31, col 31, then score 0) -> bytes 0x83, 0x1F, 0x1F then 0x40, 0x00, 0x00. cs_n high for exactly 5 cycles between packets; req_valid pulses during busy are ignored.
- Assert reset after the 10th sck rise -> cs_n=1, sck=0, mosi=0 in the same cycle with no clk edge. No done pulse. After release, req_ready=1 at the first edge and a fresh packet goes out intact.
- CLK_DIV=1; score 10'h3FF -> bytes 0x40, 0x03, 0xFF; 24 sck rises; cs_n low 49 cycles; done at t0+50.
- Colour write with req_score toggling and req_type=0 -> packet unaffected by req_score. Changing req_row during the transfer does not alter byte1.
